// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter: round-robin two-master arbiter onto one PicoRV32 memory port,
// with a per-transaction watchdog that aborts hung downstream accesses.
module picorv32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF,
    parameter bit          RESET_LAST     = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic        grant,
    output logic        busy,
    output logic        timeout_flag,
    input  logic        timeout_clr
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic        req, winner, abort, done, last;
    logic [15:0] cnt;

    assign req    = m0_mem_valid | m1_mem_valid;
    // on a tie the master that did not win last time takes the port
    assign winner = (m0_mem_valid & m1_mem_valid) ? ~last : m1_mem_valid;
    assign abort  = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !s_mem_ready && (cnt == TO_LAST);
    assign done   = (state == BUSY) && (s_mem_ready || abort);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (req ? BUSY : IDLE) : (done ? IDLE : BUSY);
    end

    always_comb begin
        busy         = state == BUSY;
        s_mem_valid  = busy;
        m0_mem_ready = done && !grant;
        m1_mem_ready = done && grant;
        m0_mem_rdata = (busy && !grant) ? (abort ? TIMEOUT_RDATA : s_mem_rdata) : '0;
        m1_mem_rdata = (busy && grant) ? (abort ? TIMEOUT_RDATA : s_mem_rdata) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant        <= 1'b0;
            last         <= RESET_LAST;
            cnt          <= '0;
            s_mem_instr  <= 1'b0;
            s_mem_addr   <= '0;
            s_mem_wdata  <= '0;
            s_mem_wstrb  <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                grant       <= winner;
                last        <= winner;
                cnt         <= '0;
                s_mem_instr <= winner ? m1_mem_instr : m0_mem_instr;
                s_mem_addr  <= winner ? m1_mem_addr  : m0_mem_addr;
                s_mem_wdata <= winner ? m1_mem_wdata : m0_mem_wdata;
                s_mem_wstrb <= winner ? m1_mem_wstrb : m0_mem_wstrb;
            end else if (state == BUSY && !s_mem_ready) begin
                cnt <= cnt + 16'd1;
            end
            if (abort)
                timeout_flag <= 1'b1;
            else if (timeout_clr)
                timeout_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb_picorv32_mem_arbiter: queue-driven masters and slave, scoreboard monitors for the
// downstream request and the upstream response.
module tb_picorv32_mem_arbiter;
    typedef struct packed {logic instr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
    typedef struct packed {logic g; req_t r;} sexp_t;
    typedef struct packed {logic m; logic [31:0] rd;} rexp_t;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
    logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
    logic [3:0]  m0_mem_wstrb;
    logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
    logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
    logic [3:0]  m1_mem_wstrb;
    logic        s_mem_valid, s_mem_instr, s_mem_ready;
    logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [3:0]  s_mem_wstrb;
    logic        grant, busy, timeout_flag, timeout_clr;

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
        .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready),
        .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
        .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready),
        .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
        .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready),
        .s_mem_rdata(s_mem_rdata),
        .grant(grant), .busy(busy), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    always #5 clk = ~clk;

    int    vectors = 0, miscompares = 0;
    req_t  q0[$], q1[$];
    sexp_t exp_s[$];
    rexp_t exp_r[$];
    int    slave_lat = 2, bc = 0;
    logic [31:0] slave_rdata = '0;
    int    bcount = 0, done_bc = 0, lat = 0, cyc = 0, rise0 = 0, rise1 = 0;
    logic  prev_sv = 1'b0, prev_done = 1'b0, pv0 = 1'b0, pv1 = 1'b0, f0, f1;
    sexp_t cur = '0;
    rexp_t e;
    req_t  r0, r1, ra, rb, rc, rd, rr, rw, rt, rk, re, rf;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
        vectors++;
        if (a !== x) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", n, a, x);
        end
    endtask

    task automatic flag_fail(input string n);
        vectors++;
        miscompares++;
        $display("FAIL %s: event missing or unexpected", n);
    endtask

    task automatic drain(input int n);
        int k = 0;
        while (k < n && !(exp_r.size() == 0 && exp_s.size() == 0 && q0.size() == 0 && q1.size() == 0
                          && !s_mem_valid && !m0_mem_valid && !m1_mem_valid)) begin
            @(negedge clk);
            k++;
        end
        if (k >= n) flag_fail("drain_timeout");
    endtask

    initial begin
        m0_mem_valid = 0; m0_mem_instr = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
        forever begin
            @(negedge clk); f0 = m0_mem_ready;
            @(posedge clk); #1;
            if (f0) m0_mem_valid = 0;
            if (!m0_mem_valid && q0.size() != 0) begin
                r0 = q0.pop_front();
                {m0_mem_instr, m0_mem_addr, m0_mem_wdata, m0_mem_wstrb} = r0;
                m0_mem_valid = 1;
            end
        end
    end

    initial begin
        m1_mem_valid = 0; m1_mem_instr = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
        forever begin
            @(negedge clk); f1 = m1_mem_ready;
            @(posedge clk); #1;
            if (f1) m1_mem_valid = 0;
            if (!m1_mem_valid && q1.size() != 0) begin
                r1 = q1.pop_front();
                {m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb} = r1;
                m1_mem_valid = 1;
            end
        end
    end

    // slave asserts ready in BUSY cycle slave_lat (0 = never)
    initial begin
        s_mem_ready = 0; s_mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (!resetn || !s_mem_valid) begin
                bc = 0;
                s_mem_ready = 0;
                s_mem_rdata = 0;
            end else begin
                bc++;
                s_mem_ready = (slave_lat != 0 && bc == slave_lat);
                s_mem_rdata = s_mem_ready ? slave_rdata : 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (prev_done) chk("s_valid_drop", s_mem_valid, 1'b0);
        if (s_mem_valid && !prev_sv) begin
            bcount = 0;
            lat = cyc - (grant ? rise1 : rise0);
            if (exp_s.size() == 0) flag_fail("unexpected_s_txn");
            else begin
                cur = exp_s.pop_front();
                chk("s_txn", {grant, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb}, cur);
            end
        end
        if (s_mem_valid) bcount++;
        if (m0_mem_ready || m1_mem_ready) begin
            done_bc = bcount;
            chk("s_hold", {grant, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb}, cur);
            if (exp_r.size() == 0) flag_fail("unexpected_ready");
            else begin
                e = exp_r.pop_front();
                chk("rsp", {m1_mem_ready, m0_mem_ready, m0_mem_rdata, m1_mem_rdata},
                    e.m ? {2'b10, 32'h0, e.rd} : {2'b01, e.rd, 32'h0});
            end
        end
        if (m0_mem_valid && !pv0) rise0 = cyc;
        if (m1_mem_valid && !pv1) rise1 = cyc;
        pv0 = m0_mem_valid; pv1 = m1_mem_valid;
        prev_done = m0_mem_ready || m1_mem_ready;
        prev_sv = s_mem_valid;
        cyc++;
    end

    initial begin
        timeout_clr = 0;
        repeat (2) @(negedge clk);
        chk("rst_s_valid", s_mem_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_readies", {m0_mem_ready, m1_mem_ready}, 2'b00);
        chk("rst_s_fields", {s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb}, 69'h0);
        chk("rst_flag", timeout_flag, 1'b0);

        ra = {1'b1, 32'h1000_0000, 32'h0000_0000, 4'h0};
        rb = {1'b0, 32'h2000_0004, 32'hAAAA_0001, 4'hF};
        rc = {1'b0, 32'h1000_0008, 32'h5555_0002, 4'h3};
        rd = {1'b0, 32'h2000_000C, 32'h0000_0000, 4'h0};
        slave_lat = 2; slave_rdata = 32'h600D_0000;
        q0.push_back(ra); q0.push_back(rc); q1.push_back(rb); q1.push_back(rd);
        exp_s.push_back({1'b0, ra}); exp_s.push_back({1'b1, rb});
        exp_s.push_back({1'b0, rc}); exp_s.push_back({1'b1, rd});
        exp_r.push_back({1'b0, 32'h600D_0000}); exp_r.push_back({1'b1, 32'h600D_0000});
        exp_r.push_back({1'b0, 32'h600D_0000}); exp_r.push_back({1'b1, 32'h600D_0000});
        @(posedge clk); #3 resetn = 1;
        drain(300);

        rr = {1'b0, 32'h4000_0010, 32'h0, 4'h0};
        slave_lat = 4; slave_rdata = 32'h1234_5678;
        q0.push_back(rr); exp_s.push_back({1'b0, rr}); exp_r.push_back({1'b0, 32'h1234_5678});
        drain(100);
        chk("arb_latency", lat, 1);
        chk("read_ready_cycle", done_bc, 4);

        rw = {1'b0, 32'h8000_0100, 32'h0000_0041, 4'b0001};
        slave_lat = 3; slave_rdata = 32'h0;
        q1.push_back(rw); exp_s.push_back({1'b1, rw}); exp_r.push_back({1'b1, 32'h0});
        drain(100);
        chk("write_ready_cycle", done_bc, 3);

        rt = {1'b0, 32'h4000_0020, 32'h0, 4'h0};
        slave_lat = 0;
        q0.push_back(rt); exp_s.push_back({1'b0, rt}); exp_r.push_back({1'b0, 32'hDEAD_BEEF});
        drain(100);
        chk("abort_cycle", done_bc, 8);
        chk("flag_set", timeout_flag, 1'b1);
        repeat (3) @(negedge clk);
        chk("flag_sticky", timeout_flag, 1'b1);
        @(posedge clk); #1 timeout_clr = 1;
        @(posedge clk); #1 timeout_clr = 0;
        @(negedge clk);
        chk("flag_cleared", timeout_flag, 1'b0);

        rk = {1'b0, 32'h4000_0024, 32'h0, 4'h0};
        slave_lat = 8; slave_rdata = 32'hCAFE_0001;
        q0.push_back(rk); exp_s.push_back({1'b0, rk}); exp_r.push_back({1'b0, 32'hCAFE_0001});
        drain(100);
        chk("late_ready_cycle", done_bc, 8);
        chk("late_ready_no_flag", timeout_flag, 1'b0);

        re = {1'b0, 32'h4000_0030, 32'h0, 4'h0};
        rf = {1'b1, 32'h2000_0040, 32'h0, 4'h0};
        slave_lat = 0;
        q0.push_back(re); exp_s.push_back({1'b0, re});
        for (int i = 0; i < 20 && !s_mem_valid; i++) begin
            @(posedge clk); #2;
        end
        if (!s_mem_valid) flag_fail("midrst_no_busy");
        @(posedge clk); #2 resetn = 0;
        #1;
        chk("midrst_s_valid", s_mem_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_m0_ready", m0_mem_ready, 1'b0);
        q1.push_back(rf);
        slave_lat = 2; slave_rdata = 32'h7777_0000;
        exp_s.push_back({1'b0, re}); exp_s.push_back({1'b1, rf});
        exp_r.push_back({1'b0, 32'h7777_0000}); exp_r.push_back({1'b1, 32'h7777_0000});
        repeat (3) @(posedge clk);
        #3 resetn = 1;
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
- Two-requester arbiter sharing one PicoRV32-native memory port between master 0 (CPU) and master 1 (debug/DMA).
- The shared port feeds the PicoRV32-to-FreeAHB adapter.
- Round-robin grant, held for one full transaction (valid through ready).
- Per-transaction timeout watchdog: aborts a hung downstream access and returns a poison word, so a stalled AHB slave cannot wedge the CPU.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in BUSY before abort; 0 disables the watchdog; max 65535 (16-bit counter).
- TIMEOUT_RDATA, 32'hDEAD_BEEF: rdata returned to the requester on abort.
- RESET_LAST, 1: value of the last-grant pointer at reset; 1 means master 0 wins the first tie.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- m0_mem_valid  in  1  master 0 request, held until m0_mem_ready
- m0_mem_instr  in  1  master 0 instruction-fetch qualifier
- m0_mem_addr  in  32  master 0 byte address
- m0_mem_wdata  in  32  master 0 write data
- m0_mem_wstrb  in  4  master 0 byte strobes; 0 means read
- m0_mem_ready  out  1  master 0 completion pulse
- m0_mem_rdata  out  32  master 0 read data, valid with ready
- m1_mem_valid, m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb, m1_mem_ready, m1_mem_rdata: same as master 0, for master 1
- s_mem_valid  out  1  downstream request
- s_mem_instr  out  1  downstream instr qualifier
- s_mem_addr  out  32  downstream address
- s_mem_wdata  out  32  downstream write data
- s_mem_wstrb  out  4  downstream strobes
- s_mem_ready  in  1  downstream completion
- s_mem_rdata  in  32  downstream read data
- grant  out  1  index of the owning master; valid while busy
- busy  out  1  transaction in flight
- timeout_flag  out  1  sticky abort indicator
- timeout_clr  in  1  synchronous clear of timeout_flag

Behaviour:
- Reset (async, resetn low):
  - State = IDLE; s_mem_valid = 0; s_mem_addr, wdata, wstrb, instr = 0.
  - busy = 0; grant = 0; last pointer = RESET_LAST; counter = 0; timeout_flag = 0.
  - Both mX_mem_ready = 0.
  - Reset mid-transaction drops s_mem_valid immediately. No upstream ready is issued.
- FSM states: IDLE, BUSY.
- IDLE:
  - On the edge where any mX_mem_valid = 1, select the winner:
    - Only one requesting: that master.
    - Both requesting: the master not equal to the last pointer.
  - Register the winner's addr, wdata, wstrb, instr into s_*; set s_mem_valid = 1, busy = 1, grant = winner; last pointer = winner; counter = 0. Go to BUSY.
  - Arbitration latency: s_mem_valid rises one cycle after the request is sampled.
- BUSY:
  - s_* outputs held stable; upstream inputs ignored until done.
  - mGRANT_mem_ready = s_mem_ready (combinational). mGRANT_mem_rdata = s_mem_rdata.
  - The non-granted master's ready = 0 and rdata = 0.
  - On an edge with s_mem_ready = 1: s_mem_valid = 0, busy = 0, go to IDLE.
  - Back-to-back transactions have one IDLE cycle between them. Re-arbitration happens at that IDLE edge, so requests arriving during BUSY are served in round-robin order.
- Watchdog, active when TIMEOUT_CYCLES != 0:
  - Counter increments each BUSY cycle with s_mem_ready = 0.
  - When the counter equals TIMEOUT_CYCLES-1 and s_mem_ready = 0, abort for one cycle:
    - mGRANT_mem_ready = 1 and mGRANT_mem_rdata = TIMEOUT_RDATA (combinational in that cycle).
    - Then s_mem_valid = 0, timeout_flag = 1, go to IDLE.
  - s_mem_ready = 1 in the abort cycle takes priority: normal completion, no flag set.
  - Writes abort the same way; rdata is don't-care for writes.
- timeout_flag:
  - Sticky; cleared on an edge with timeout_clr = 1.
  - When set and clear coincide, set wins.
- Requester protocol violations (valid dropped before ready) are ignored. The latched transaction completes downstream.
- s_mem_ready outside BUSY is ignored.

Test Plan:
- Single read: m0 valid, addr 0x4000_0010, wstrb 0. Slave readies 3 cycles after s_mem_valid with rdata 0x1234_5678. Required: s_mem_valid rises 1 cycle after the request; m0_mem_ready pulses 1 cycle with rdata 0x1234_5678; m1_mem_ready stays 0.
- Contention: m0 and m1 both valid from reset, each re-requesting immediately after ready. Required grant order 0,1,0,1 over 4 transactions; addrs and strobes on s_* match the owner for each.
- Write pass-through: m1 write, addr 0x8000_0100, wdata 0x0000_0041, wstrb 4'b0001. Required: s_* carry exactly those values, stable until s_mem_ready; m1_mem_ready pulses once.
- Timeout: TIMEOUT_CYCLES=8, slave never readies. Required: m0_mem_ready pulses in the 8th BUSY cycle with rdata 0xDEAD_BEEF; s_mem_valid drops the next cycle; timeout_flag = 1 until timeout_clr is pulsed.
- Ready in the abort cycle: TIMEOUT_CYCLES=8, slave readies in BUSY cycle 8 with rdata 0xCAFE_0001. Required: rdata 0xCAFE_0001 returned; timeout_flag stays 0.
- Reset mid-operation: assert resetn low in BUSY cycle 2. Required: s_mem_valid = 0 asynchronously, no upstream ready; after release, the first arbitration grants master 0 under contention.
